i2c_master_byte_ctrl: RTL and testbench

//  Single-master I2C transaction controller. It sequences the shared open-drain SDA/SCL lines that the SDA_Slave block samples and drives.
//  One command = START, 7-bit address + R/W, address ACK, one data byte (write or read), data ACK/NACK, STOP.

---
 rtl/i2c_master_byte_ctrl.sv | 150 +++++++++++++++
 tb/tb_i2c_master_byte_ctrl.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_master_byte_ctrl.sv
// Single-master I2C byte controller: START, address+R/W, ACK, one data byte, ACK/NACK, STOP.
// Drives open-drain enables only; the pads turn o_*_oe into a low pull or high-Z.
module i2c_master_byte_ctrl #(
  parameter int CLK_DIV = 4
) (
  input  logic       i_clk,
  input  logic       i_reset_n,
  input  logic       i_cmd_valid,
  output logic       o_cmd_ready,
  input  logic [6:0] i_addr,
  input  logic       i_rw,
  input  logic [7:0] i_wdata,
  output logic [7:0] o_rdata,
  output logic       o_done,
  output logic       o_nack,
  output logic       o_busy,
  input  logic       i_sda,
  output logic       o_sda_oe,
  output logic       o_scl_oe
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_ADDR, S_ADDR_ACK, S_WDATA, S_RDATA, S_DATA_ACK, S_STOP
  } state_t;

  state_t           state_q, state_d;
  logic [DIV_W-1:0] div_q;
  logic [1:0]       qtr_q;
  logic [2:0]       bit_q;
  logic [6:0]       addr_q;
  logic             rw_q;
  logic [7:0]       wdata_q;
  logic [7:0]       shift_q;
  logic             nack_q;

  logic       accept, tick, step_end, sample, last_bit, scl_pulse, tx_bit;
  logic [7:0] tx_byte;

  assign o_cmd_ready = (state_q == S_IDLE);
  assign o_busy      = (state_q != S_IDLE);
  assign accept      = i_cmd_valid && o_cmd_ready;
  assign tick        = o_busy && (div_q == DIV_MAX);
  assign step_end    = tick && (qtr_q == 2'd3);
  assign sample      = tick && (qtr_q == 2'd1);
  assign last_bit    = (bit_q == 3'd7);
  // SCL is pulled low in q0 and q3 of every data/ack bit, released in q1/q2.
  assign scl_pulse   = (qtr_q == 2'd0) || (qtr_q == 2'd3);
  assign tx_byte     = (state_q == S_ADDR) ? {addr_q, rw_q} : wdata_q;
  assign tx_bit      = tx_byte[3'd7 - bit_q];

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) state_q <= S_IDLE;
    else            state_q <= state_d;
  end

  always_comb begin
    // NOTE: every output of this block gets a default first so no path can infer a latch.
    state_d  = state_q;
    o_sda_oe = 1'b0;
    o_scl_oe = 1'b0;
    case (state_q)
      S_IDLE: if (accept) state_d = S_START;
      S_START: begin
        o_sda_oe = qtr_q[1];
        o_scl_oe = (qtr_q == 2'd3);
        if (step_end) state_d = S_ADDR;
      end
      S_ADDR: begin
        o_sda_oe = ~tx_bit;
        o_scl_oe = scl_pulse;
        if (step_end && last_bit) state_d = S_ADDR_ACK;
      end
      S_ADDR_ACK: begin
        o_scl_oe = scl_pulse;
        if (step_end) state_d = nack_q ? S_STOP : (rw_q ? S_RDATA : S_WDATA);
      end
      S_WDATA: begin
        o_sda_oe = ~tx_bit;
        o_scl_oe = scl_pulse;
        if (step_end && last_bit) state_d = S_DATA_ACK;
      end
      S_RDATA: begin
        o_scl_oe = scl_pulse;
        if (step_end && last_bit) state_d = S_DATA_ACK;
      end
      S_DATA_ACK: begin
        o_scl_oe = scl_pulse;
        if (step_end) state_d = S_STOP;
      end
      S_STOP: begin
        o_sda_oe = (qtr_q <= 2'd1);
        o_scl_oe = (qtr_q == 2'd0);
        if (step_end) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state updates use non-blocking assignments so all registers see pre-edge values.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      div_q   <= '0;
      qtr_q   <= 2'd0;
      bit_q   <= 3'd0;
      addr_q  <= 7'h00;
      rw_q    <= 1'b0;
      wdata_q <= 8'h00;
      shift_q <= 8'h00;
      nack_q  <= 1'b0;
      o_done  <= 1'b0;
      o_nack  <= 1'b0;
      o_rdata <= 8'h00;
    end else begin
      o_done <= 1'b0;
      if (accept) begin
        addr_q  <= i_addr;
        rw_q    <= i_rw;
        wdata_q <= i_wdata;
        nack_q  <= 1'b0;
        o_nack  <= 1'b0;
        div_q   <= '0;
        qtr_q   <= 2'd0;
        bit_q   <= 3'd0;
      end else if (o_busy) begin
        div_q <= tick ? '0 : div_q + DIV_W'(1);
        if (tick) qtr_q <= qtr_q + 2'd1;
        // Slave data is taken mid-way through SCL high.
        if (sample) begin
          case (state_q)
            S_ADDR_ACK: nack_q  <= i_sda;
            S_DATA_ACK: if (!rw_q && i_sda) nack_q <= 1'b1;
            S_RDATA:    shift_q <= {shift_q[6:0], i_sda};
            default: ;
          endcase
        end
        if (step_end && (state_q == S_ADDR || state_q == S_WDATA || state_q == S_RDATA))
          bit_q <= bit_q + 3'd1;
        if (step_end && state_q == S_STOP) begin
          o_done <= 1'b1;
          o_nack <= nack_q;
          if (rw_q) o_rdata <= shift_q;
        end
      end
    end
  end

endmodule

// File: tb/tb_i2c_master_byte_ctrl.sv
// Scoreboard bench for i2c_master_byte_ctrl with a behavioural I2C slave on the resolved bus.
// Stimulus queues expectations; the negedge monitor compares them whenever o_done pulses.
module tb_i2c_master_byte_ctrl;

  localparam int CLK_DIV = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       rw = 1'b0;
  logic [6:0] addr = 7'h00;
  logic [7:0] wdata = 8'h00;
  logic       cmd_ready, done, nack, busy, sda_oe, scl_oe, sda;
  logic [7:0] rdata;
  logic       slave_pull = 1'b0;

  assign sda = ~(sda_oe | slave_pull);

  typedef struct {
    int          lat;
    logic        nack;
    logic        is_read;
    logic [7:0]  rdata;
    int          nbits;
    logic [31:0] bits;
  } exp_t;

  typedef struct {
    string       name;
    logic [31:0] act;
    logic [31:0] exp;
  } probe_t;

  exp_t   exp_q[$];
  probe_t probe_q[$];

  int n_cmp = 0;
  int n_err = 0;

  logic       ack_addr = 1'b1;
  logic       ack_data = 1'b1;
  logic [7:0] slave_byte = 8'h00;

  int          cycle_cnt = 0;
  int          acc_cyc = 0;
  int          done_cyc = 0;
  int          n_done = 0;
  int          nbits = 0;
  int          n_stops = 0;
  logic [31:0] cap = 32'h0;
  logic        prev_scl = 1'b1;
  logic        prev_sda = 1'b1;
  logic        slave_rw = 1'b0;

  i2c_master_byte_ctrl #(.CLK_DIV(CLK_DIV)) dut (
    .i_clk(clk), .i_reset_n(rst_n), .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready),
    .i_addr(addr), .i_rw(rw), .i_wdata(wdata), .o_rdata(rdata), .o_done(done),
    .o_nack(nack), .o_busy(busy), .i_sda(sda), .o_sda_oe(sda_oe), .o_scl_oe(scl_oe)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycle_cnt++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic probe(input string name, input logic [31:0] act, input logic [31:0] exp);
    probe_t p;
    p.name = name;
    p.act  = act;
    p.exp  = exp;
    probe_q.push_back(p);
  endtask

  function automatic exp_t mk(int lat, logic nk, logic rd, logic [7:0] rb, int nb, logic [31:0] bits);
    exp_t e;
    e.lat = lat; e.nack = nk; e.is_read = rd; e.rdata = rb; e.nbits = nb; e.bits = bits;
    return e;
  endfunction

  // Monitor: bus decode, slave responses, and scoreboard comparison on o_done.
  always @(negedge clk) begin : monitor
    probe_t p;
    exp_t   e;
    logic   scl_v, sda_v;
    while (probe_q.size() > 0) begin
      p = probe_q.pop_front();
      check(p.name, p.act, p.exp);
    end
    scl_v = ~scl_oe;
    sda_v = sda;
    if (!rst_n) begin
      slave_pull = 1'b0;
      nbits = 0;
      cap = 32'h0;
      n_stops = 0;
    end else begin
      if (prev_scl && scl_v && prev_sda && !sda_v) begin
        nbits = 0;
        cap = 32'h0;
        n_stops = 0;
      end
      if (prev_scl && scl_v && !prev_sda && sda_v) n_stops++;
      if (!prev_scl && scl_v) begin
        cap = {cap[30:0], sda_v};
        nbits++;
      end
      if (prev_scl && !scl_v) begin
        if (nbits == 8) begin
          slave_rw = cap[0];
          slave_pull = ack_addr;
        end else if (nbits >= 9 && nbits <= 16)
          slave_pull = slave_rw && ack_addr && !slave_byte[16 - nbits];
        else if (nbits == 17)
          slave_pull = !slave_rw && ack_data;
        else
          slave_pull = 1'b0;
      end
      if (done) begin
        n_done++;
        done_cyc = cycle_cnt;
        if (exp_q.size() == 0) begin
          check("unexpected_done", 32'(exp_q.size()), 32'd1);
        end else begin
          e = exp_q.pop_front();
          check("latency", 32'(cycle_cnt - acc_cyc), 32'(e.lat));
          check("nack", 32'(nack), 32'(e.nack));
          if (e.is_read) check("rdata", 32'(rdata), 32'(e.rdata));
          check("bit_count", 32'(nbits), 32'(e.nbits));
          check("bus_bits", cap, e.bits);
          check("stop_seen", 32'(n_stops), 32'd1);
        end
      end
      if (cmd_valid && cmd_ready) acc_cyc = cycle_cnt + 1;
    end
    prev_scl = scl_v;
    prev_sda = sda_v;
  end

  task automatic wait_busy_posedge();
    logic ok = 1'b0;
    for (int k = 0; k < 100 && !ok; k++) begin
      @(posedge clk);
      #1;
      ok = busy;
    end
    probe("accept_timeout", 32'(ok), 32'd1);
  endtask

  task automatic send(input logic [6:0] a, input logic r, input logic [7:0] d, input exp_t e);
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    addr = a; rw = r; wdata = d; cmd_valid = 1'b1;
    wait_busy_posedge();
    cmd_valid = 1'b0; addr = ~a; rw = ~r; wdata = ~d;
  endtask

  task automatic wait_done(input int target);
    for (int k = 0; k < 3000 && n_done < target; k++) @(negedge clk);
    probe("done_timeout", 32'(n_done >= target), 32'd1);
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int   n0;
    logic ok;
    #1;
    probe("rst_ready", 32'(cmd_ready), 32'd1);
    probe("rst_sda_oe", 32'(sda_oe), 32'd0);
    probe("rst_scl_oe", 32'(scl_oe), 32'd0);
    probe("rst_done", 32'(done), 32'd0);
    probe("rst_nack", 32'(nack), 32'd0);
    probe("rst_busy", 32'(busy), 32'd0);
    probe("rst_rdata", 32'(rdata), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // 1: write 0x50 / 0xA5, both ACKed
    ack_addr = 1'b1; ack_data = 1'b1;
    n0 = n_done;
    send(7'h50, 1'b0, 8'hA5, mk(320, 1'b0, 1'b0, 8'h00, 19, 32'b1010000_0_0_10100101_0_0));
    wait_done(n0 + 1);

    // 2: read 0x29, slave returns 0x3C
    slave_byte = 8'h3C;
    n0 = n_done;
    send(7'h29, 1'b1, 8'h00, mk(320, 1'b0, 1'b1, 8'h3C, 19, 32'b0101001_1_0_00111100_1_0));
    wait_done(n0 + 1);

    // 3: address NACK
    ack_addr = 1'b0;
    n0 = n_done;
    send(7'h33, 1'b0, 8'h77, mk(176, 1'b1, 1'b0, 8'h00, 10, 32'b0110011_0_1_0));
    wait_done(n0 + 1);

    // 4: address ACK, data NACK
    ack_addr = 1'b1; ack_data = 1'b0;
    n0 = n_done;
    send(7'h12, 1'b0, 8'h5A, mk(320, 1'b1, 1'b0, 8'h00, 19, 32'b0010010_0_0_01011010_1_0));
    wait_done(n0 + 1);

    // 5: reset during WDATA bit 3 (bit is 0, so SDA and SCL both pulled in q3)
    ack_data = 1'b1;
    send(7'h2B, 1'b0, 8'hE7, mk(320, 1'b0, 1'b0, 8'h00, 19, 32'h0));
    ok = 1'b0;
    for (int k = 0; k < 1000 && !ok; k++) begin
      @(negedge clk);
      ok = (nbits == 13);
    end
    probe("bit3_timeout", 32'(ok), 32'd1);
    repeat (2 * CLK_DIV) @(negedge clk);
    #2;
    probe("pre_rst_sda_oe", 32'(sda_oe), 32'd1);
    probe("pre_rst_scl_oe", 32'(scl_oe), 32'd1);
    rst_n = 1'b0;
    #1;
    probe("midrst_sda_oe", 32'(sda_oe), 32'd0);
    probe("midrst_scl_oe", 32'(scl_oe), 32'd0);
    probe("midrst_busy", 32'(busy), 32'd0);
    exp_q.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    probe("post_rst_ready", 32'(cmd_ready), 32'd1);
    n0 = n_done;
    send(7'h0F, 1'b0, 8'hC3, mk(320, 1'b0, 1'b0, 8'h00, 19, 32'b0001111_0_0_11000011_0_0));
    wait_done(n0 + 1);

    // 6: valid held high; fields change while busy become the second command
    n0 = n_done;
    exp_q.push_back(mk(320, 1'b0, 1'b0, 8'h00, 19, 32'b1100001_0_0_00111100_0_0));
    @(posedge clk);
    #1;
    addr = 7'h61; rw = 1'b0; wdata = 8'h3C; cmd_valid = 1'b1;
    wait_busy_posedge();
    addr = 7'h05; wdata = 8'hF0;
    exp_q.push_back(mk(320, 1'b0, 1'b0, 8'h00, 19, 32'b0000101_0_0_11110000_0_0));
    repeat (100) @(negedge clk);
    probe("busy_ready", 32'(cmd_ready), 32'd0);
    probe("busy_busy", 32'(busy), 32'd1);
    wait_done(n0 + 1);
    ok = 1'b0;
    for (int k = 0; k < 20 && !ok; k++) begin
      @(negedge clk);
      ok = busy;
    end
    probe("second_accept", 32'(ok), 32'd1);
    cmd_valid = 1'b0; addr = 7'h7F; wdata = 8'h00;
    probe("accept_gap", 32'(acc_cyc - done_cyc), 32'd1);
    wait_done(n0 + 2);

    probe("leftover_expect", 32'(exp_q.size()), 32'd0);
    repeat (4) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
